// File: rtl/mini_ram_pkg.sv
// Shared constants for the mini RAM front-end: FSM encoding and bus widths.
package mini_ram_pkg;

    // Controller state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] INIT    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RSP     = 2'd3;

    // RAM data width and the width of the RAM address bus
    localparam int RAM_DW        = 8;
    localparam int MAX_ADDR_BITS = 8;

endpackage

// File: rtl/mini_sp_ram.sv
// 8-bit single-port RAM with a registered read port (data valid the cycle
// after a read strobe). Accesses whose upper address bits are non-zero are
// outside the array and are ignored.
module mini_sp_ram
    import mini_ram_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic                     we,
    input  logic [MAX_ADDR_BITS-1:0] addr,
    input  logic [RAM_DW-1:0]        din,
    output logic [RAM_DW-1:0]        dout
);

    logic [RAM_DW-1:0]    r_mem [0:(1<<ADDR_BITS)-1];
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_in_range;

    assign w_idx      = addr[ADDR_BITS-1:0];
    assign w_in_range = ((addr >> ADDR_BITS) == '0);

    // Array write, or registered read into dout
    always_ff @(posedge clk) begin
        if (ce && w_in_range) begin
            if (we) begin
                r_mem[w_idx] <= din;
            end else begin
                dout <= r_mem[w_idx];
            end
        end
    end

endmodule

// File: rtl/mini_ram_ctrl.sv
// Request/response front-end for mini_sp_ram: turns a valid/ready request
// stream into RAM strobes, absorbs the RAM read latency, holds read data
// under backpressure, and zero-fills the RAM on demand.
module mini_ram_ctrl
    import mini_ram_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_start,
    output logic                     init_busy,
    output logic                     init_done,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [MAX_ADDR_BITS-1:0] req_addr,
    input  logic [RAM_DW-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RAM_DW-1:0]        rsp_rdata,
    output logic [MAX_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_DW-1:0]        ram_din,
    output logic                     ram_ce,
    output logic                     ram_we,
    input  logic [RAM_DW-1:0]        ram_dout
);

    // Keeps only the address bits that exist in the RAM
    localparam logic [MAX_ADDR_BITS-1:0] ADDR_MASK =
        MAX_ADDR_BITS'((9'd1 << ADDR_BITS) - 9'd1);

    logic [1:0]               r_state;
    logic [ADDR_BITS-1:0]     r_cnt;
    logic                     r_rsp_valid;
    logic [RAM_DW-1:0]        r_rsp_rdata;
    logic                     r_init_done;

    logic                     w_accept;
    logic                     w_fill_last;
    logic [MAX_ADDR_BITS-1:0] w_req_addr_m;

    // init_start wins over a same-cycle request, so it also withholds ready
    assign req_ready    = rst_n && (r_state == IDLE) && !init_start;
    assign w_accept     = req_valid && req_ready;
    assign w_fill_last  = (r_cnt == {ADDR_BITS{1'b1}});
    assign w_req_addr_m = req_addr & ADDR_MASK;

    assign init_busy = (r_state == INIT);
    assign init_done = r_init_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    // RAM pin drive: fill writes, or the accepted request in the same cycle
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (rst_n) begin
            if (r_state == INIT) begin
                ram_ce   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = MAX_ADDR_BITS'(r_cnt);
            end else if (w_accept) begin
                ram_ce   = 1'b1;
                ram_we   = req_we;
                ram_addr = w_req_addr_m;
                ram_din  = req_we ? req_wdata : '0;
            end
        end
    end

    // Control FSM, fill counter and response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_start) begin
                        r_state <= INIT;
                    end else if (w_accept && !req_we) begin
                        r_state <= RD_WAIT;
                    end
                end
                INIT: begin
                    if (w_fill_last) begin
                        r_cnt       <= '0;
                        r_init_done <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + ADDR_BITS'(1);
                    end
                end
                RD_WAIT: begin
                    r_rsp_rdata <= ram_dout;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_ram_ctrl.sv
// Directed bench for mini_ram_ctrl driving a mini_sp_ram (ADDR_BITS = 4).
module tb_mini_ram_ctrl;
    import mini_ram_pkg::*;

    localparam int AB    = 4;
    localparam int DEPTH = 1 << AB;

    logic       clk;
    logic       rst_n;
    logic       init_start;
    logic       init_busy;
    logic       init_done;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_ce;
    logic       ram_we;
    logic [7:0] ram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    mini_ram_ctrl #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    mini_sp_ram #(.ADDR_BITS(AB)) u_ram (
        .clk(clk), .ce(ram_ce), .we(ram_we), .addr(ram_addr),
        .din(ram_din), .dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        #1;
        for (int i = 0; i < 40 && !req_ready; i++) tick();
        tick();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d, output bit ok);
        ok = 1'b0; d = 8'h00;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 40 && !req_ready; i++) tick();
        if (req_ready) begin
            tick();
            req_valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (rsp_valid) begin
                    d = rsp_rdata; ok = 1'b1;
                    break;
                end
                tick();
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h01; req_wdata = 8'h55;
        tick(); tick();
        n_tests++;
        if (req_ready !== 1'b0 || ram_ce !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pins: ready/ce/we=%b%b%b expected 000", req_ready, ram_ce, ram_we);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || init_busy !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rsp_valid=%b rdata=%h busy=%b done=%b expected 0 00 0 0",
                     rsp_valid, rsp_rdata, init_busy, init_done);
        end
        req_valid = 1'b0; rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_init();
        int bad;
        init_start = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || ram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL init_start_ready: ready=%b ce=%b expected 0 0", req_ready, ram_ce);
        end
        tick();
        init_start = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            init_start = (i == 3);     // must be ignored while filling
            #1;
            if (init_busy !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 ||
                ram_addr !== 8'(i) || ram_din !== 8'h00 || req_ready !== 1'b0 || init_done !== 1'b0) begin
                bad++;
                $display("FAIL init_cycle%0d: busy=%b ce=%b we=%b addr=%h din=%h expected 1 1 1 %h 00",
                         i, init_busy, ram_ce, ram_we, ram_addr, ram_din, 8'(i));
            end
            tick();
        end
        init_start = 1'b0;
        n_tests++;
        if (bad != 0) n_fail++;
        n_tests++;
        if (init_busy !== 1'b0 || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_end: busy=%b done=%b ready=%b expected 0 1 1", init_busy, init_done, req_ready);
        end
        tick();
        n_tests++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done_pulse: got %b expected 0", init_done);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        bit ok;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 8'hA5;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h02 || ram_din !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_pins: ready=%b ce=%b we=%b addr=%h din=%h expected 1 1 1 02 a5",
                     req_ready, ram_ce, ram_we, ram_addr, ram_din);
        end
        tick();
        req_we = 1'b0; rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h02) begin
            n_fail++;
            $display("FAIL rd_pins: ce=%b we=%b addr=%h expected 1 0 02", ram_ce, ram_we, ram_addr);
        end
        tick();
        req_valid = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait: rsp_valid=%b ready=%b ce=%b expected 0 0 0", rsp_valid, req_ready, ram_ce);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_latency: rsp_valid=%b rdata=%h expected 1 a5", rsp_valid, rsp_rdata);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_done: rsp_valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
        do_read(8'h02, d, ok);
        n_tests++;
        if (!ok || d !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_alias: ok=%b data=%h expected 1 a5", ok, d);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        #1;
        tick();
        req_addr = 8'h07;              // a second read that must wait
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || req_ready !== 1'b0 || ram_ce !== 1'b0) begin
                bad++;
                $display("FAIL bp_cycle%0d: rsp_valid=%b rdata=%h ready=%b ce=%b expected 1 a5 0 0",
                         i, rsp_valid, rsp_rdata, req_ready, ram_ce);
            end
            tick();
        end
        n_tests++;
        if (bad != 0) n_fail++;
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [7:0] d;
        bit ok;
        bad = 0;
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 8'(i); req_wdata = 8'(i);
            #1;
            if (req_ready !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 ||
                ram_addr !== 8'(i) || ram_din !== 8'(i)) begin
                bad++;
                $display("FAIL b2b_wr%0d: ready=%b ce=%b we=%b addr=%h din=%h expected 1 1 1 %h %h",
                         i, req_ready, ram_ce, ram_we, ram_addr, ram_din, 8'(i), 8'(i));
            end
            tick();
        end
        req_valid = 1'b0; req_we = 1'b0;
        n_tests++;
        if (bad != 0) n_fail++;
        for (int i = 0; i < 8; i++) begin
            do_read(8'(i), d, ok);
            n_tests++;
            if (!ok || d !== 8'(i)) begin
                n_fail++;
                $display("FAIL b2b_rd%0d: ok=%b data=%h expected 1 %h", i, ok, d, 8'(i));
            end
        end
    endtask

    task automatic test_init_priority();
        int cyc;
        bit early;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h03; rsp_ready = 1'b1;
        init_start = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || ram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_same_cycle: ready=%b ce=%b expected 0 0", req_ready, ram_ce);
        end
        tick();
        init_start = 1'b0;
        cyc = 0; early = 1'b0;
        while (!init_done && cyc < 40) begin
            if (req_ready) early = 1'b1;
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc != DEPTH || early) begin
            n_fail++;
            $display("FAIL prio_fill: cycles=%0d early_ready=%b expected %0d 0", cyc, early, DEPTH);
        end
        n_tests++;
        if (req_ready !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h03) begin
            n_fail++;
            $display("FAIL prio_accept: ready=%b ce=%b we=%b addr=%h expected 1 1 0 03",
                     req_ready, ram_ce, ram_we, ram_addr);
        end
        tick();
        req_valid = 1'b0;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_rsp: rsp_valid=%b rdata=%h expected 1 00", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        logic [7:0] exp;
        bit ok;
        bit seen;
        int cyc;
        do_write(8'h09, 8'h3C);
        do_write(8'h0C, 8'h6A);
        do_write(8'h03, 8'h11);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        cyc = 0;
        while (!(init_busy && ram_addr == 8'h05) && cyc < 40) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL abort_reach5: cycles=%0d expected 5", cyc);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ram_ce !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pins: ce=%b ready=%b expected 0 0", ram_ce, req_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (init_busy !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b ready=%b rsp_valid=%b expected 0 0 1 0",
                     init_busy, init_done, req_ready, rsp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (init_done || init_busy) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_done: busy/done seen=%b expected 0", seen);
        end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] a;
            a   = (i < 5) ? 8'(i) : ((i == 5) ? 8'h09 : 8'h0C);
            exp = (i < 5) ? 8'h00 : ((i == 5) ? 8'h3C : 8'h6A);
            do_read(a, d, ok);
            n_tests++;
            if (!ok || d !== exp) begin
                n_fail++;
                $display("FAIL abort_rd_%h: ok=%b data=%h expected 1 %h", a, ok, d, exp);
            end
        end
        // Reset while a response is being held
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h09;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL rsp_hold: rsp_valid=%b rdata=%h expected 1 3c", rsp_valid, rsp_rdata);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_abort: rsp_valid=%b rdata=%h ready=%b expected 0 00 1",
                     rsp_valid, rsp_rdata, req_ready);
        end
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL rsp_abort_quiet: rsp_valid seen=%b expected 0", seen);
        end
        do_read(8'h09, d, ok);
        n_tests++;
        if (!ok || d !== 8'h3C) begin
            n_fail++;
            $display("FAIL rsp_abort_reread: ok=%b data=%h expected 1 3c", ok, d);
        end
    endtask

    initial begin
        rst_n = 1'b0; init_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;
        test_reset();
        test_init();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_init_priority();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
